// File: rtl/sbqm_queue_core_pkg.sv
// Shared constants for the single-server queue manager: default counter width,
// wait-time output width and the service time charged per waiting customer.
package sbqm_queue_core_pkg;

    localparam int N_DEFAULT = 3;
    localparam int WTIME_W   = N_DEFAULT + 2;
    localparam int SVC_TIME  = 3;

endpackage

// File: rtl/sbqm_queue_core_wait_time_rom.sv
// Registered wait-time estimate: floor(SVC_TIME*(pcount+tcount-1)/tcount), 0 when
// the queue is empty or no teller is active. One cycle latency, no backpressure.
module wait_time_rom
    import sbqm_queue_core_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   pcount,
    input  logic [1:0]     tcount,
    output logic [N+1:0]   wtime
);

    localparam int AW = N + 3;
    localparam int WW = N + 2;

    logic [AW-1:0] num;
    logic [AW-1:0] quo;
    logic [WW-1:0] wtime_d;
    logic [WW-1:0] wtime_q;

    always_comb begin
        num = AW'(SVC_TIME) * (AW'(pcount) + AW'(tcount) - AW'(1));
        quo = '0;
        // Teller count is at most 3, so the divide collapses to three constant cases.
        case (tcount)
            2'd1:    quo = num;
            2'd2:    quo = num >> 1;
            2'd3:    quo = num / AW'(3);
            default: quo = '0;
        endcase
        wtime_d = (pcount == '0) ? '0 : WW'(quo);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wtime_q <= '0;
        end else begin
            wtime_q <= wtime_d;
        end
    end

    assign wtime = wtime_q;

endmodule

// File: rtl/sbqm_queue_core.sv
// Saturating queue occupancy counter with registered full/empty flags and wait-time estimate.
// Latency: count/flags one cycle, Wtime one cycle after Pcount/Tcount. No backpressure.
module sbqm_queue_core
    import sbqm_queue_core_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           dec,
    input  logic [1:0]     Tcount,
    output logic [N-1:0]   Pcount,
    output logic [N+1:0]   Wtime,
    output logic           Full_F,
    output logic           Empty_F
);

    localparam logic [N-1:0] P_MAX = '1;

    logic [N-1:0] pcount_d, pcount_q;
    logic         full_d,   full_q;
    logic         empty_d,  empty_q;

    always_comb begin
        pcount_d = pcount_q;
        case ({inc, dec})
            2'b10: if (pcount_q != P_MAX) pcount_d = pcount_q + N'(1);
            2'b01: if (pcount_q != '0)    pcount_d = pcount_q - N'(1);
            // An arrival and a departure cancel, but nobody can be served from an empty queue.
            2'b11: if (pcount_q == '0)    pcount_d = N'(1);
            default: ;
        endcase
        full_d  = (pcount_d == P_MAX);
        empty_d = (pcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcount_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            pcount_q <= pcount_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    wait_time_rom #(.N(N)) u_wait_time_rom (
        .clk    (clk),
        .rst    (rst),
        .pcount (pcount_q),
        .tcount (Tcount),
        .wtime  (Wtime)
    );

    assign Pcount  = pcount_q;
    assign Full_F  = full_q;
    assign Empty_F = empty_q;

endmodule

// File: tb/tb_sbqm_queue_core.sv
// Directed scoreboard bench for sbqm_queue_core: the driver queues the expected
// post-edge state per cycle, a negedge monitor pops and compares.
module tb_sbqm_queue_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc;
    logic       dec;
    logic [1:0] tcount;
    logic [2:0] pcount;
    logic [4:0] wtime;
    logic       full_f;
    logic       empty_f;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [4:0] w;
        bit         chk_w;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [2:0] fill_exp  [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    logic [2:0] drain_exp [9] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    logic [4:0] dec_w_exp [5] = '{5'd9, 5'd7, 5'd6, 5'd4, 5'd3};

    sbqm_queue_core #(.N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .Tcount  (tcount),
        .Pcount  (pcount),
        .Wtime   (wtime),
        .Full_F  (full_f),
        .Empty_F (empty_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Apply inputs for the next edge and queue the state expected right after it.
    task automatic step(input logic r, input logic i, input logic d, input logic [1:0] t,
                        input logic [2:0] ep, input logic [4:0] ew, input bit cw,
                        input string nm);
        exp_t e;
        rst    = r;
        inc    = i;
        dec    = d;
        tcount = t;
        e.cyc   = cyc + 1;
        e.p     = ep;
        e.w     = ew;
        e.chk_w = cw;
        e.name  = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cyc >= 2) begin
            checks++;
            if (full_f === 1'b1 && empty_f === 1'b1) begin
                failures++;
                $display("FAIL flags_exclusive: Full_F=1 Empty_F=1, expected at most one high (cycle %0d)", cyc);
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                chk({mon_e.name, "_pcount"}, {5'd0, pcount}, {5'd0, mon_e.p});
                chk({mon_e.name, "_full"},   {7'd0, full_f},  {7'd0, (mon_e.p == 3'd7)});
                chk({mon_e.name, "_empty"},  {7'd0, empty_f}, {7'd0, (mon_e.p == 3'd0)});
                if (mon_e.chk_w)
                    chk({mon_e.name, "_wtime"}, {3'd0, wtime}, {3'd0, mon_e.w});
            end
        end
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL watchdog: stimulus did not complete, expected completion before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b0; inc = 1'b0; dec = 1'b0; tcount = 2'd0;
        @(posedge clk);
        #1;

        step(0, 0, 0, 0, 0, 0, 1, "reset1");
        step(0, 1, 0, 0, 0, 0, 1, "reset2");

        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, fill_exp[i], 0, 1, "fill");
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, drain_exp[i], 0, 1, "drain");

        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 3'(i + 1), 0, 1, "up_to_4");
        step(1, 1, 1, 0, 4, 0, 1, "sim_at_4");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 3'(3 - i), 0, 1, "down_to_0");
        step(1, 1, 1, 0, 1, 0, 1, "sim_at_0");
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 3'(i + 2), 0, 1, "up_to_7");
        step(1, 1, 1, 0, 7, 0, 1, "sim_at_7");

        step(1, 0, 0, 1, 7, 21, 1, "rom_7_1");
        step(1, 0, 0, 3, 7, 9,  1, "rom_7_3");
        step(1, 0, 0, 0, 7, 0,  1, "rom_7_0");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 3'(6 - i), 0, 1, "down_to_3");
        step(1, 0, 0, 1, 3, 9, 1, "rom_3_1");
        step(1, 0, 0, 2, 3, 6, 1, "rom_3_2");
        step(1, 1, 0, 0, 4, 0, 1, "up_to_5");
        step(1, 1, 0, 0, 5, 0, 1, "up_to_5");
        step(1, 0, 0, 2, 5, 9, 1, "rom_5_2");
        step(1, 0, 0, 0, 5, 0, 1, "rom_5_0");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 2, 3'(4 - i), dec_w_exp[i], 1, "dec_t2");
        step(1, 0, 0, 2, 0, 0, 1, "rom_0_2");

        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 3'(i + 1), 0, 0, "ramp_5");
        step(1, 0, 0, 1, 5, 15, 1, "rom_5_1");
        step(0, 1, 0, 1, 0, 0,  1, "rst_mid");
        step(1, 1, 0, 1, 1, 0,  1, "rst_release");
        step(1, 0, 0, 1, 1, 3,  1, "rom_1_1");

        inc = 1'b0; dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbqm_queue_core.md
SBQM_QUEUE_CORE -- requirements
Module: sbqm_queue_core

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning the queue-count width (maximum occupancy 2^N-1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 inc  input  1  customer-entered event; one event per cycle it is sampled high.
REQ-005 dec  input  1  customer-served event; one event per cycle it is sampled high.
REQ-006 Tcount  input  2  number of active tellers (0..3).
REQ-007 Pcount  output  N  current number of people in the queue.
REQ-008 Wtime  output  N+2  estimated wait time in time units.
REQ-009 Full_F  output  1  high when Pcount equals 2^N-1.
REQ-010 Empty_F  output  1  high when Pcount equals 0.

Function
REQ-011 Pcount SHALL be a registered up/down counter updated every rising clk edge.
REQ-012 inc only: Pcount+1, except at 2^N-1, where it SHALL hold (saturate, no wrap to 0).
REQ-013 dec only: Pcount-1, except at 0, where it SHALL hold (saturate, no wrap to 2^N-1).
REQ-014 inc and dec together: Pcount SHALL be unchanged, except at 0, where it SHALL become 1.
REQ-015 Neither asserted: Pcount SHALL hold.
REQ-016 Full_F and Empty_F SHALL be registered and valid in the same cycle as the Pcount value they describe (decoded from the counter's next value).
REQ-017 Full_F and Empty_F SHALL never be high simultaneously.
REQ-018 Wtime SHALL be registered: one cycle after Pcount/Tcount are presented, Wtime = floor(3*(Pcount+Tcount-1)/Tcount).
REQ-019 Wtime SHALL be 0 when Pcount is 0 or Tcount is 0.
REQ-020 Wtime arithmetic SHALL use at least N+3 bits internally; the result (max 21 for N=3) SHALL fit N+2 bits without truncation.
REQ-021 Tcount changes SHALL be reflected in Wtime with the same one-cycle latency, independent of inc/dec.

Reset
REQ-022 With rst low at a rising edge: Pcount=0, Empty_F=1, Full_F=0, Wtime=0.
REQ-023 Reset SHALL override inc/dec in the same cycle, including mid-operation at any count.
REQ-024 First count change SHALL occur at the first rising edge after rst returns high with inc or dec sampled high.

Structure
REQ-025 A shared package SHALL hold N default (3), WTIME_W (N+2), and the service-time-per-customer constant (3).
REQ-026 The wait-time lookup SHALL be one sub-module, wait_time_rom (registered, inputs Pcount and Tcount, output Wtime); counter and flag logic stay in the top.

Verification
REQ-027 Reset: rst low two cycles -> Pcount=0, Empty_F=1, Full_F=0, Wtime=0.
REQ-028 Fill: 9 inc pulses from 0 -> Pcount steps 1..7 then holds 7; Full_F=1 from Pcount=7; Empty_F=0 after first inc.
REQ-029 Drain: 9 dec pulses from 7 -> Pcount steps 6..0 then holds 0; Full_F drops at 6; Empty_F=1 at 0.
REQ-030 Simultaneous: inc+dec at Pcount=4 -> stays 4; at 0 -> 1; at 7 -> stays 7 with Full_F=1.
REQ-031 ROM table: (Pcount,Tcount) (3,1)->9, (3,2)->6, (7,3)->9, (7,1)->21, (5,0)->0, (0,2)->0, each one cycle after inputs settle.
REQ-032 Reset mid-run: rst low at Pcount=5 with inc high -> next edge Pcount=0, Empty_F=1, Wtime=0.
